// File: rtl/otter_mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, with sign correction applied in a final FIX cycle.
module otter_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [2:0]       mdu_fun,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  logic [1:0]       state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [2:0]       fun_reg;
  logic             a_neg_reg, b_neg_reg, div_zero_reg;
  logic [WIDTH-1:0] opnd_reg;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] shift_reg;  // multiplier bits out / product low, or dividend in / quotient
  logic [WIDTH-1:0] acc_reg;    // product high half, or partial remainder
  logic [WIDTH-1:0] a_raw_reg;
  logic [WIDTH-1:0] result_reg;
  logic             busy_reg, done_reg;

  // Operand decode at start
  logic             is_div, signed_a, signed_b, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    is_div   = mdu_fun[2];
    signed_a = is_div ? ~mdu_fun[0] : (mdu_fun[1:0] != 2'b11);
    signed_b = is_div ? ~mdu_fun[0] : ~mdu_fun[1];
    a_neg    = signed_a & A[WIDTH-1];
    b_neg    = signed_b & B[WIDTH-1];
    a_mag    = a_neg ? (~A + 1'b1) : A;
    b_mag    = b_neg ? (~B + 1'b1) : B;
  end

  // One iteration step for each datapath
  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_trial;
  logic           div_ok;

  always_comb begin
    mul_sum   = {1'b0, acc_reg} + (shift_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
    div_trial = {acc_reg, shift_reg[WIDTH-1]} - {1'b0, opnd_reg};
    div_ok    = ~div_trial[WIDTH];
  end

  // Sign correction and result select
  logic [2*WIDTH-1:0] product, product_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, fix_value;
  logic               sign_diff;

  always_comb begin
    sign_diff   = a_neg_reg ^ b_neg_reg;
    product     = {acc_reg, shift_reg};
    product_fix = sign_diff ? (~product + 1'b1) : product;
    quot_fix    = sign_diff ? (~shift_reg + 1'b1) : shift_reg;
    rem_fix     = a_neg_reg ? (~acc_reg + 1'b1) : acc_reg;
    case (fun_reg)
      3'b000:                 fix_value = product_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_value = product_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_value = div_zero_reg ? {WIDTH{1'b1}} : quot_fix;
      default:                fix_value = div_zero_reg ? a_raw_reg : rem_fix;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      fun_reg      <= '0;
      a_neg_reg    <= 1'b0;
      b_neg_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      opnd_reg     <= '0;
      shift_reg    <= '0;
      acc_reg      <= '0;
      a_raw_reg    <= '0;
      result_reg   <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          busy_reg <= 1'b0;
          if (start) begin
            state_reg    <= ST_CALC;
            cnt_reg      <= '0;
            acc_reg      <= '0;
            fun_reg      <= mdu_fun;
            a_neg_reg    <= a_neg;
            b_neg_reg    <= b_neg;
            div_zero_reg <= (B == '0);
            a_raw_reg    <= A;
            // Multiply shifts B out of shift_reg; divide shifts A out of it
            opnd_reg     <= is_div ? b_mag : a_mag;
            shift_reg    <= is_div ? a_mag : b_mag;
          end
        end
        ST_CALC: begin
          busy_reg <= 1'b1;
          if (fun_reg[2]) begin
            if (div_ok) begin
              acc_reg   <= div_trial[WIDTH-1:0];
              shift_reg <= {shift_reg[WIDTH-2:0], 1'b1};
            end else begin
              acc_reg   <= {acc_reg[WIDTH-2:0], shift_reg[WIDTH-1]};
              shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_reg   <= mul_sum[WIDTH:1];
            shift_reg <= {mul_sum[0], shift_reg[WIDTH-1:1]};
          end
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(WIDTH - 1)) state_reg <= ST_FIX;
        end
        ST_FIX: begin
          busy_reg   <= 1'b0;
          done_reg   <= 1'b1;
          result_reg <= fix_value;
          state_reg  <= ST_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign result = result_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_otter_mdu.sv
// Directed vector bench for otter_mdu: result values, 33-cycle latency, busy
// window, and the start/reset handshake corner cases.
module tb_otter_mdu;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [2:0]  mdu_fun;
  logic [31:0] A, B;
  logic [31:0] result;
  logic        busy, done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  otter_mdu #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .start(start), .mdu_fun(mdu_fun),
    .A(A), .B(B), .result(result), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [2:0]  fun;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic launch(input logic [2:0] fun, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; mdu_fun = fun; A = a; B = b;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0; mdu_fun = 3'($urandom); A = $urandom; B = $urandom;
  endtask

  // Counts edges after the start edge until done (lat=0 if none within 40).
  task automatic wait_done(input int poke_at, input int rst_at, output int lat, output int busyc);
    lat = 0; busyc = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (busy) busyc++;
      if (done) begin lat = k; break; end
      if (k == poke_at) begin start = 1'b1; mdu_fun = 3'b000; A = 32'd3; B = 32'd3; end
      else if (k == poke_at + 1) start = 1'b0;
      if (k == rst_at) RST = 1'b1;
      else if (k == rst_at + 1) RST = 1'b0;
    end
  endtask

  int lat, busyc;
  logic [31:0] held;

  initial begin
    vecs[0]  = '{"mul_7x6",       3'b000, 32'd7,        32'd6,        32'd42};
    vecs[1]  = '{"mul_m1x5",      3'b000, 32'hFFFFFFFF, 32'd5,        32'hFFFFFFFB};
    vecs[2]  = '{"mulh_m1x5",     3'b001, 32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF};
    vecs[3]  = '{"mulhu_m1x5",    3'b011, 32'hFFFFFFFF, 32'd5,        32'h00000004};
    vecs[4]  = '{"mulhsu_m1",     3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[5]  = '{"mulh_min_sq",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[6]  = '{"div_m7_2",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
    vecs[7]  = '{"rem_m7_2",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
    vecs[8]  = '{"divu_big_2",    3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC};
    vecs[9]  = '{"remu_big_2",    3'b111, 32'hFFFFFFF9, 32'd2,        32'd1};
    vecs[10] = '{"divu_by0",      3'b101, 32'd123,      32'd0,        32'hFFFFFFFF};
    vecs[11] = '{"rem_by0",       3'b110, 32'd123,      32'd0,        32'd123};
    vecs[12] = '{"remu_by0",      3'b111, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF};
    vecs[13] = '{"div_overflow",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[14] = '{"rem_overflow",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0};

    RST = 1'b1; start = 1'b0; mdu_fun = 3'b000; A = '0; B = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check("reset_result", result, 32'd0);
    check("reset_busy",   {31'd0, busy}, 32'd0);
    check("reset_done",   {31'd0, done}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      launch(vecs[i].fun, vecs[i].a, vecs[i].b);
      wait_done(-10, -10, lat, busyc);
      $display("op %-13s fun=%0d A=%08h B=%08h -> result=%08h latency=%0d", vecs[i].name,
               vecs[i].fun, vecs[i].a, vecs[i].b, result, lat);
      check({vecs[i].name, "_latency"}, 32'(lat), 32'd33);
      check({vecs[i].name, "_result"}, result, vecs[i].exp);
      check({vecs[i].name, "_busy_cycles"}, 32'(busyc), 32'd32);
      check({vecs[i].name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      held = result;
      @(posedge CLK);
      @(negedge CLK);
      check({vecs[i].name, "_done_1cyc"}, {31'd0, done}, 32'd0);
      check({vecs[i].name, "_held"}, result, held);
    end

    // start pulsed mid-operation is ignored
    launch(3'b100, 32'd1000, 32'hFFFFFFF6);
    wait_done(10, -10, lat, busyc);
    $display("op div_poked     result=%08h latency=%0d", result, lat);
    check("poke_latency", 32'(lat), 32'd33);
    check("poke_result",  result, 32'hFFFFFF9C);
    wait_done(-10, -10, lat, busyc);
    check("poke_no_extra_done", 32'(lat), 32'd0);

    // start raised during the done cycle is accepted
    launch(3'b100, 32'd100, 32'd7);
    wait_done(-10, -10, lat, busyc);
    check("b2b_first_latency", 32'(lat), 32'd33);
    check("b2b_first_result",  result, 32'd14);
    launch(3'b110, 32'hFFFFFF9C, 32'd7);
    wait_done(-10, -10, lat, busyc);
    $display("op rem_in_done   result=%08h latency=%0d", result, lat);
    check("b2b_second_latency", 32'(lat), 32'd33);
    check("b2b_second_result",  result, 32'hFFFFFFFE);

    // reset mid-operation aborts with no done
    launch(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(-10, 15, lat, busyc);
    $display("op abort         result=%08h busy=%0b done_latency=%0d", result, busy, lat);
    check("abort_no_done", 32'(lat), 32'd0);
    check("abort_result",  result, 32'd0);
    check("abort_busy",    {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
